gpio_port_bank: RTL and testbench

//  Parametrised multi-port GPIO bank for the pad-ring designs: NPORTS ports of WIDTH bits each.
//  Per-bit direction, atomic set/clear/toggle, synchronised inputs and edge-triggered interrupts.

---
 rtl/gpio_port_bank.sv | 232 +++++++++++++++++++++++
 tb/tb_gpio_port_bank.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_bank.sv
// ---------------------------------------------------------------------------
// gpio_port_bank
//   NPORTS x WIDTH general-purpose I/O bank behind the internal register bus.
//   Each port has OUT/DIR registers with atomic set/clear/toggle aliases,
//   a synchronised input view, and per-bit edge-triggered interrupt flags.
//
// Ports
//   clk      core clock, rising edge
//   RESETn   asynchronous active-low reset
//   addr     {port index, reg offset[3:0]}
//   wr_en    write strobe (one cycle per access)
//   rd_en    read strobe (one cycle per access)
//   wdata    write data
//   rdata    registered read data, valid the cycle after rd_en, held until next read
//   pad_in   raw pad inputs (asynchronous to clk)
//   pad_out  OUT registers, port p at [p*WIDTH +: WIDTH]
//   pad_oe   DIR registers (1 = drive)
//   irq      registered OR over ports of (IFLAG & IE)
//
// Register offsets (per port)
//   0 OUT  1 DIR  2 IN(ro)  3 OUTSET  4 OUTCLR  5 OUTTGL  6 IE
//   7 IRISE  8 IANY  9 IFLAG(W1C)  10..15 reserved (read 0)
// ---------------------------------------------------------------------------

// Per-port slice: registers, input synchroniser, edge detect, flags.
//   i_we       write strobe already qualified for this port
//   i_reg      register offset
//   i_wdata    write data
//   i_evt_en   low during post-reset warm-up; masks edge events
//   i_pad      raw pad inputs of this port
//   o_out      OUT register
//   o_dir      DIR register
//   o_rdata    combinational read value for i_reg
//   o_irq_src  any enabled flag pending in this port
module gpio_port_lane #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RESETn,
  input  logic             i_we,
  input  logic [3:0]       i_reg,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_evt_en,
  input  logic [WIDTH-1:0] i_pad,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_dir,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_irq_src
);

  localparam logic [3:0] R_OUT    = 4'd0;
  localparam logic [3:0] R_DIR    = 4'd1;
  localparam logic [3:0] R_IN     = 4'd2;
  localparam logic [3:0] R_OUTSET = 4'd3;
  localparam logic [3:0] R_OUTCLR = 4'd4;
  localparam logic [3:0] R_OUTTGL = 4'd5;
  localparam logic [3:0] R_IE     = 4'd6;
  localparam logic [3:0] R_IRISE  = 4'd7;
  localparam logic [3:0] R_IANY   = 4'd8;
  localparam logic [3:0] R_IFLAG  = 4'd9;

  logic [WIDTH-1:0] r_out, r_dir, r_ie, r_irise, r_iany, r_iflag, r_prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

  logic [WIDTH-1:0] w_in, w_rise, w_fall, w_evt, w_clr;

  // Last synchroniser stage is the architectural IN value.
  assign w_in   = r_sync[SYNC_STAGES-1];
  assign w_rise = w_in & ~r_prev;
  assign w_fall = ~w_in & r_prev;

  // IANY takes priority over IRISE; otherwise IRISE picks rise vs fall.
  assign w_evt = i_evt_en ?
                 ((r_iany & (w_rise | w_fall)) |
                  (~r_iany &  r_irise & w_rise) |
                  (~r_iany & ~r_irise & w_fall)) : '0;

  assign w_clr = (i_we && i_reg == R_IFLAG) ? i_wdata : '0;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_prev <= w_in;
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_ie    <= '0;
      r_irise <= '0;
      r_iany  <= '0;
    end else if (i_we) begin
      case (i_reg)
        R_OUT:    r_out   <= i_wdata;
        R_DIR:    r_dir   <= i_wdata;
        R_OUTSET: r_out   <= r_out | i_wdata;
        R_OUTCLR: r_out   <= r_out & ~i_wdata;
        R_OUTTGL: r_out   <= r_out ^ i_wdata;
        R_IE:     r_ie    <= i_wdata;
        R_IRISE:  r_irise <= i_wdata;
        R_IANY:   r_iany  <= i_wdata;
        default:  ;
      endcase
    end
  end

  // Set is OR'd in after the clear, so a same-cycle event beats W1C.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) r_iflag <= '0;
    else         r_iflag <= (r_iflag & ~w_clr) | w_evt;
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      R_OUT:   o_rdata = r_out;
      R_DIR:   o_rdata = r_dir;
      R_IN:    o_rdata = w_in;
      R_IE:    o_rdata = r_ie;
      R_IRISE: o_rdata = r_irise;
      R_IANY:  o_rdata = r_iany;
      R_IFLAG: o_rdata = r_iflag;
      default: o_rdata = '0;
    endcase
  end

  assign o_out     = r_out;
  assign o_dir     = r_dir;
  assign o_irq_src = |(r_iflag & r_ie);

endmodule

module gpio_port_bank #(
  parameter  int WIDTH       = 8,
  parameter  int NPORTS      = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = $clog2(NPORTS) + 4
) (
  input  logic                    clk,
  input  logic                    RESETn,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  input  logic [NPORTS*WIDTH-1:0] pad_in,
  output logic [NPORTS*WIDTH-1:0] pad_out,
  output logic [NPORTS*WIDTH-1:0] pad_oe,
  output logic                    irq
);

  localparam int WARM = SYNC_STAGES + 1;
  localparam int WCW  = $clog2(WARM + 1);

  logic [ADDR_W-1:0]             w_port;
  logic [3:0]                    w_reg;
  logic [NPORTS-1:0]             w_we;
  logic [NPORTS-1:0]             w_irq_src;
  logic [NPORTS-1:0][WIDTH-1:0]  w_out, w_dir, w_lane_rd;
  logic [WIDTH-1:0]              w_rd;
  logic                          w_evt_en;

  logic [WCW-1:0]                r_warm;
  logic [WIDTH-1:0]              r_rdata;
  logic                          r_irq;

  assign w_port = addr >> 4;
  assign w_reg  = addr[3:0];

  // Warm-up: hold off edge events until the synchronisers and history
  // flops hold real pad state, so pads high at reset raise no flags.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn)                    r_warm <= '0;
    else if (r_warm != WCW'(WARM))  r_warm <= r_warm + 1'b1;
  end
  assign w_evt_en = (r_warm == WCW'(WARM));

  genvar p;
  generate
    for (p = 0; p < NPORTS; p++) begin : g_port
      // Out-of-range port indices never match, so those writes are dropped.
      assign w_we[p] = wr_en && (w_port == ADDR_W'(p));

      gpio_port_lane #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_lane (
        .clk       (clk),
        .RESETn    (RESETn),
        .i_we      (w_we[p]),
        .i_reg     (w_reg),
        .i_wdata   (wdata),
        .i_evt_en  (w_evt_en),
        .i_pad     (pad_in[p*WIDTH +: WIDTH]),
        .o_out     (w_out[p]),
        .o_dir     (w_dir[p]),
        .o_rdata   (w_lane_rd[p]),
        .o_irq_src (w_irq_src[p])
      );
    end
  endgenerate

  // Read mux; unmatched (out-of-range) ports read as 0.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NPORTS; i++)
      if (w_port == ADDR_W'(i)) w_rd = w_lane_rd[i];
  end

  // Sampled before any same-cycle write lands, so rd+wr returns old data.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn)    r_rdata <= '0;
    else if (rd_en) r_rdata <= w_rd;
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) r_irq <= 1'b0;
    else         r_irq <= |w_irq_src;
  end

  assign rdata   = r_rdata;
  assign irq     = r_irq;
  assign pad_out = w_out;
  assign pad_oe  = w_dir;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Bench for gpio_port_bank. Three ports are instantiated so that port
// index 3 is encodable in the address and lands out of range.
module tb_gpio_port_bank;

  localparam int WIDTH  = 8;
  localparam int NPORTS = 3;
  localparam int SYNC   = 2;
  localparam int AW     = $clog2(NPORTS) + 4;
  localparam int TW     = NPORTS * WIDTH;

  logic          clk;
  logic          RESETn;
  logic [AW-1:0] addr;
  logic          wr_en, rd_en;
  logic [7:0]    wdata, rdata;
  logic [TW-1:0] pad_in, pad_out, pad_oe;
  logic          irq;

  gpio_port_bank #(.WIDTH(WIDTH), .NPORTS(NPORTS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .RESETn(RESETn), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .pad_in(pad_in), .pad_out(pad_out),
    .pad_oe(pad_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]    m_out[NPORTS], m_dir[NPORTS], m_ie[NPORTS];
  logic [7:0]    m_irise[NPORTS], m_iany[NPORTS], m_iflag[NPORTS];
  logic [TW-1:0] m_in, m_prev, m_q[$], cur_pad;
  int            m_warm;
  logic          m_irq;
  logic [7:0]    m_rdata;

  task automatic model_reset();
    for (int p = 0; p < NPORTS; p++) begin
      m_out[p] = 0; m_dir[p] = 0; m_ie[p] = 0;
      m_irise[p] = 0; m_iany[p] = 0; m_iflag[p] = 0;
    end
    m_in = 0; m_prev = 0; m_warm = 0; m_irq = 0; m_rdata = 0;
    m_q.delete();
    for (int i = 0; i < SYNC - 1; i++) m_q.push_back('0);
  endtask

  function automatic logic [7:0] m_read(logic [AW-1:0] a);
    int p = int'(a) / 16;
    int r = int'(a) % 16;
    if (p >= NPORTS) return 8'h00;
    case (r)
      0: return m_out[p];
      1: return m_dir[p];
      2: return m_in[p*8 +: 8];
      6: return m_ie[p];
      7: return m_irise[p];
      8: return m_iany[p];
      9: return m_iflag[p];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_events(int p);
    logic [7:0] e = 0;
    for (int b = 0; b < 8; b++) begin
      logic now_v = m_in[p*8 + b];
      logic old_v = m_prev[p*8 + b];
      if (now_v !== old_v) begin
        if (m_iany[p][b])       e[b] = 1'b1;
        else if (m_irise[p][b]) e[b] = now_v;
        else                    e[b] = !now_v;
      end
    end
    return e;
  endfunction

  task automatic model_step(bit wr, bit rd, logic [AW-1:0] a, logic [7:0] d);
    logic [7:0] evt[NPORTS];
    logic irq_n = 1'b0;
    int p = int'(a) / 16;
    int r = int'(a) % 16;
    for (int i = 0; i < NPORTS; i++) begin
      evt[i] = (m_warm >= SYNC + 1) ? m_events(i) : 8'h00;
      if ((m_iflag[i] & m_ie[i]) != 0) irq_n = 1'b1;
    end
    if (rd) m_rdata = m_read(a);
    if (wr && p < NPORTS) begin
      case (r)
        0: m_out[p] = d;
        1: m_dir[p] = d;
        3: m_out[p] = m_out[p] | d;
        4: m_out[p] = m_out[p] & ~d;
        5: m_out[p] = m_out[p] ^ d;
        6: m_ie[p] = d;
        7: m_irise[p] = d;
        8: m_iany[p] = d;
        9: m_iflag[p] = m_iflag[p] & ~d;
        default: ;
      endcase
    end
    for (int i = 0; i < NPORTS; i++) m_iflag[i] = m_iflag[i] | evt[i];
    m_irq = irq_n;
    m_q.push_back(cur_pad);
    m_prev = m_in;
    m_in = m_q.pop_front();
    if (m_warm < 1000) m_warm++;
  endtask

  function automatic logic [TW-1:0] flat(logic [7:0] v[NPORTS]);
    logic [TW-1:0] f = 0;
    for (int p = 0; p < NPORTS; p++) f[p*8 +: 8] = v[p];
    return f;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(bit wr, bit rd, logic [AW-1:0] a, logic [7:0] d);
    wr_en = wr; rd_en = rd; addr = a; wdata = d; pad_in = cur_pad;
    model_step(wr, rd, a, d);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
    chk("pad_out", pad_out, flat(m_out));
    chk("pad_oe",  pad_oe,  flat(m_dir));
    chk("irq",     irq,     m_irq);
    chk("rdata",   rdata,   m_rdata);
  endtask

  task automatic wr_reg(logic [AW-1:0] a, logic [7:0] d);
    cycle(1, 0, a, d);
  endtask

  task automatic rd_reg(logic [AW-1:0] a, output logic [7:0] v);
    cycle(0, 1, a, 8'h00);
    v = rdata;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 8'h00);
  endtask

  task automatic do_reset(logic [TW-1:0] pad);
    RESETn = 0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
    cur_pad = pad; pad_in = pad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pad_out", pad_out, '0);
    chk("rst_pad_oe",  pad_oe,  '0);
    chk("rst_irq",     irq,     1'b0);
    chk("rst_rdata",   rdata,   8'h00);
    model_reset();
    RESETn = 1;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wr, logic [AW-1:0] a, logic [7:0] d, logic [7:0] exp);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.exp = exp;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] v;
    logic [TW-1:0] base;
    logic [AW-1:0] ra;

    RESETn = 0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
    pad_in = 0; cur_pad = 0;
    model_reset();

    // Atomic ops, reserved/write-only offsets, out-of-range port.
    tbl.push_back(mk(1, 6'h00, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 6'h00, 8'h00, 8'hA5));
    tbl.push_back(mk(1, 6'h03, 8'h0A, 8'h00));
    tbl.push_back(mk(0, 6'h00, 8'h00, 8'hAF));
    tbl.push_back(mk(1, 6'h04, 8'h81, 8'h00));
    tbl.push_back(mk(0, 6'h00, 8'h00, 8'h2E));
    tbl.push_back(mk(1, 6'h05, 8'hFF, 8'h00));
    tbl.push_back(mk(0, 6'h00, 8'h00, 8'hD1));
    tbl.push_back(mk(0, 6'h03, 8'h00, 8'h00));
    tbl.push_back(mk(1, 6'h01, 8'hF0, 8'h00));
    tbl.push_back(mk(0, 6'h01, 8'h00, 8'hF0));
    tbl.push_back(mk(1, 6'h0C, 8'h55, 8'h00));
    tbl.push_back(mk(0, 6'h0C, 8'h00, 8'h00));
    tbl.push_back(mk(1, 6'h30, 8'h77, 8'h00));
    tbl.push_back(mk(0, 6'h30, 8'h00, 8'h00));
    tbl.push_back(mk(1, 6'h21, 8'h3C, 8'h00));
    tbl.push_back(mk(0, 6'h21, 8'h00, 8'h3C));
    tbl.push_back(mk(0, 6'h11, 8'h00, 8'h00));
    tbl.push_back(mk(1, 6'h12, 8'hFF, 8'h00));
    tbl.push_back(mk(0, 6'h12, 8'h00, 8'h00));
    tbl.push_back(mk(0, 6'h00, 8'h00, 8'hD1));

    // Reset with all pads high: no flags once running.
    do_reset('1);
    idle(6);
    for (int p = 0; p < NPORTS; p++) begin
      rd_reg(AW'(p*16 + 9), v);
      chk("rst_iflag", v, 8'h00);
    end
    chk("rst_irq_run", irq, 1'b0);
    chk("rst_oe_run", pad_oe, '0);

    do_reset('0);
    idle(4);

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr_reg(tbl[i].a, tbl[i].d);
      else begin
        rd_reg(tbl[i].a, v);
        chk("tbl_rd", v, tbl[i].exp);
      end
    end
    chk("pad_out_p0", pad_out[7:0], 8'hD1);

    // Sync latency, port 1 bit 0.
    cur_pad = 24'h000100;
    rd_reg(6'h12, v); chk("sync_e1", v, 8'h00);
    rd_reg(6'h12, v); chk("sync_e2", v, 8'h00);
    rd_reg(6'h12, v); chk("sync_e3", v, 8'h01);

    // Rising edge on port 1 bit 3.
    base = 24'h000100;
    wr_reg(6'h16, 8'h08);
    wr_reg(6'h17, 8'h08);
    cur_pad = base | 24'h000800;
    cycle(0, 0, '0, 8'h00); chk("rise_irq1", irq, 1'b0);
    cycle(0, 0, '0, 8'h00); chk("rise_irq2", irq, 1'b0);
    cycle(0, 0, '0, 8'h00); chk("rise_irq3", irq, 1'b0);
    cycle(0, 0, '0, 8'h00); chk("rise_irq4", irq, 1'b1);
    rd_reg(6'h19, v); chk("rise_flag", v, 8'h08);
    wr_reg(6'h19, 8'h08);
    idle(1); chk("w1c_irq", irq, 1'b0);

    // Falling-only mode.
    wr_reg(6'h17, 8'h00);
    cur_pad = base; idle(4);
    rd_reg(6'h19, v); chk("fall_flag", v, 8'h08);
    wr_reg(6'h19, 8'h08);
    cur_pad = base | 24'h000800; idle(4);
    rd_reg(6'h19, v); chk("fall_norise", v, 8'h00);

    // Both edges.
    wr_reg(6'h18, 8'h08);
    cur_pad = base; idle(4);
    rd_reg(6'h19, v); chk("any_fall", v, 8'h08);
    wr_reg(6'h19, 8'h08);
    cur_pad = base | 24'h000800; idle(4);
    rd_reg(6'h19, v); chk("any_rise", v, 8'h08);
    wr_reg(6'h19, 8'h08);
    idle(2);

    // Collision: W1C on the same edge the new rise sets the flag.
    wr_reg(6'h18, 8'h00);
    wr_reg(6'h17, 8'h08);
    cur_pad = base; idle(4);
    cur_pad = base | 24'h000800; idle(4);
    chk("col_pre_irq", irq, 1'b1);
    cur_pad = base; idle(4);
    cur_pad = base | 24'h000800;
    cycle(0, 0, '0, 8'h00);
    cycle(0, 0, '0, 8'h00);
    cycle(1, 0, 6'h19, 8'h08);
    chk("col_irq_a", irq, 1'b1);
    rd_reg(6'h19, v); chk("col_flag", v, 8'h08);
    chk("col_irq_b", irq, 1'b1);

    // Read and write OUT in the same cycle.
    cycle(1, 1, 6'h00, 8'h3C);
    chk("rdwr_old", rdata, 8'hD1);
    rd_reg(6'h00, v); chk("rdwr_new", v, 8'h3C);

    // Asynchronous reset between clock edges.
    #2 RESETn = 0;
    #1;
    chk("async_pad_out", pad_out, '0);
    chk("async_pad_oe",  pad_oe,  '0);
    chk("async_irq",     irq,     1'b0);
    chk("async_rdata",   rdata,   8'h00);
    do_reset('0);
    idle(4);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit wr = ($urandom_range(0, 2) == 0);
      bit rd = ($urandom_range(0, 1) == 0);
      ra[5:4] = 2'($urandom_range(0, 3));
      ra[3:0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        cur_pad = cur_pad ^ (TW'(1) << $urandom_range(0, TW - 1));
      if ($urandom_range(0, 15) == 0)
        cur_pad = TW'($urandom);
      cycle(wr, rd, ra, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
